// File: rtl/display_scan_pkg.sv
// Shared constants for the 4-digit display scan path.
package display_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;
endpackage

// File: rtl/display_scan_if.sv
// Data/control bundle between the timer logic and the display scanner.
interface display_scan_if;
  import display_pkg::*;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [3:0]              sayac;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    dp;
  logic                    scan_tick;

  modport master (output digits_in, dp_in, load, input sayac, anode, dp, scan_tick);
  modport slave  (input digits_in, dp_in, load, output sayac, anode, dp, scan_tick);
endinterface

// File: rtl/display_scan_prescaler.sv
// Modulo-SCAN_DIV slot counter; exposes its next value and terminal count.
module scan_prescaler #(
  parameter int SCAN_DIV = 100000,
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;

  always_comb begin
    tc      = (cnt == CNT_W'(SCAN_DIV - 1));
    cnt_nxt = tc ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
endmodule

// File: rtl/display_scan.sv
// Multiplexes a frame-synchronous 4-digit BCD value onto one decoder input
// with active-low anodes, anode dead-time and optional leading-zero blanking.
module display_scan
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16,
  parameter int LZ_BLANK  = 1,
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  display_scan_if.slave  bus
);
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    tc;
  logic [1:0]              idx, idx_nxt;
  logic                    frame;
  logic                    in_dead;
  logic [4*NUM_DIGITS-1:0] shadow_dig, active_dig, active_dig_nxt;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp, active_dp_nxt;
  logic                    pending;

  function automatic logic [3:0] slot_code(input logic [4*NUM_DIGITS-1:0] d,
                                           input logic [1:0] k, input logic lz);
    logic all_zero;
    all_zero = 1'b1;
    // Digit k is a leading zero only if it and every more significant digit are zero.
    for (int j = NUM_DIGITS - 1; j >= 1; j--) begin
      if (j >= int'(k) && d[4*j +: 4] != 4'd0) all_zero = 1'b0;
    end
    if (lz && k != 2'd0 && all_zero) return BLANK_CODE;
    return d[4*k +: 4];
  endfunction

  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_nxt (cnt_nxt),
    .tc      (tc)
  );

  generate
    if (BLANK_CYC == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (cnt_nxt < CNT_W'(BLANK_CYC));
    end
  endgenerate

  // A load landing on the frame boundary bypasses the shadow register.
  always_comb begin
    idx_nxt        = tc ? idx + 2'd1 : idx;
    frame          = tc && (idx == 2'd3);
    active_dig_nxt = active_dig;
    active_dp_nxt  = active_dp;
    if (frame) begin
      if (bus.load) begin
        active_dig_nxt = bus.digits_in;
        active_dp_nxt  = bus.dp_in;
      end else if (pending) begin
        active_dig_nxt = shadow_dig;
        active_dp_nxt  = shadow_dp;
      end
    end
  end

  // Stage p1: outputs are computed from next state so they are valid in slot cycle 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx           <= 2'd0;
      shadow_dig    <= '0;
      shadow_dp     <= '0;
      active_dig    <= '0;
      active_dp     <= '0;
      pending       <= 1'b0;
      bus.sayac     <= 4'd0;
      bus.anode     <= ANODE_OFF;
      bus.dp        <= 1'b1;
      bus.scan_tick <= 1'b0;
    end else begin
      idx <= idx_nxt;
      if (bus.load) begin
        shadow_dig <= bus.digits_in;
        shadow_dp  <= bus.dp_in;
      end
      if (frame)         pending <= 1'b0;
      else if (bus.load) pending <= 1'b1;
      active_dig    <= active_dig_nxt;
      active_dp     <= active_dp_nxt;
      bus.sayac     <= slot_code(active_dig_nxt, idx_nxt, LZ_BLANK != 0);
      bus.dp        <= ~active_dp_nxt[idx_nxt];
      bus.anode     <= in_dead ? ANODE_OFF : ~(4'b0001 << idx_nxt);
      bus.scan_tick <= frame;
    end
  end
endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Upstream neighbour of the 7-segment decoder in the 4-digit timer display path.
- Holds a 4-digit BCD value and time-multiplexes it onto one shared decoder input and four active-low digit anodes.
- Adds a frame-synchronous update (no tearing), per-slot anode dead-time (anti-ghosting) and optional leading-zero blanking.
- Drives the decoder's 4-bit code input; the decoder turns all segments off for codes 10–15, so code 4'hF is the blank code.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot; legal range ≥ 2.
BLANK_CYC, 16, cycles at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYC < SCAN_DIV.
LZ_BLANK, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  reset, synchronous, active-low.
digits_in  input  16  four BCD digits; [3:0] = digit0 (rightmost, least significant), [15:12] = digit3.
dp_in  input  4  decimal-point request per digit, 1 = lit; bit k belongs to digit k.
load  input  1  one-cycle strobe; captures digits_in and dp_in.
sayac  output  4  code to the 7-segment decoder for the current slot; registered.
anode  output  4  digit enables, active-low, one-hot-low or all-ones; registered.
dp  output  1  decimal point, active-low; registered.
scan_tick  output  1  one-cycle pulse on the first cycle of every digit0 slot (frame start).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Prescaler = 0, digit index = 0, shadow and active digit registers = 0, dp registers = 0, pending = 0.
  - Outputs: anode = 4'b1111, sayac = 4'd0, dp = 1, scan_tick = 0.
  - Reset applied mid-operation behaves the same, abandoning any pending load.
- Prescaler: counts 0..SCAN_DIV-1 and wraps.
  - A slot is SCAN_DIV cycles long.
  - At the wrap, the digit index advances 0→1→2→3→0.
  - A full frame is 4·SCAN_DIV cycles.
- Slot start (prescaler == 0), with all outputs registered and valid in that cycle:
  - sayac = the (possibly blanked) code of the active digit.
  - dp = ~active_dp[index].
  - anode = 4'b1111.
- Dead-time: anode stays 4'b1111 while prescaler < BLANK_CYC. From prescaler == BLANK_CYC to the end of the slot, anode[index] = 0 and all other bits = 1. With BLANK_CYC = 0 the anode is enabled in the slot-start cycle.
- Load path:
  - When load=1, the shadow register ← {digits_in, dp_in} and pending ← 1.
  - Repeated loads before a frame start: the last one wins.
- Frame boundary (index wraps 3→0):
  - If pending, active ← shadow and pending ← 0. The new value appears from that digit0 slot onward, so no frame ever mixes old and new digits.
  - If load and the boundary coincide, the value captured in that same cycle is applied directly at that boundary (bypass), and pending ends 0.
- scan_tick: 1 exactly in the cycle where index=0 and prescaler=0. It is not asserted in the first cycle after reset release; the first pulse occurs at the first wrap into digit0.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k (k = 3, 2, 1) is blanked (sayac = 4'hF) when active digits k..3 are all 4'd0.
  - Digit0 is never blanked.
  - dp is unaffected by blanking.
- Non-BCD digit values 10–15 pass through unchanged (the decoder shows blank) and count as non-zero for blanking.
- No combinational path from any input to any output.

Decomposition:
- Shared package (display_pkg): NUM_DIGITS = 4, BLANK_CODE = 4'hF, ANODE_OFF = 4'b1111.
- One natural sub-module: scan_prescaler (parameterised modulo-SCAN_DIV counter with a terminal-count output).
- Blanking, the load/shadow logic and the output registers stay in display_scan.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, LZ_BLANK=1 unless noted):
1. rst_n=0 for 3 cycles → anode=1111, sayac=0, dp=1, scan_tick=0. After release: digit0 slot, sayac=0, anode=1110 from the 3rd cycle of the slot; displays "   0".
2. load with digits_in=16'h1234, dp_in=4'b0100 → from the next frame start, slots give sayac 4,3,2,1 with anodes 1110,1101,1011,0111, each enabled for cycles 2..7 of its slot; dp=0 only in the digit2 slot; scan_tick every 32 cycles.
3. Load 16'h0050 → sayac F,F,5,0 for digits 3..0. Load 16'h0000 → F,F,F,0. Repeat 16'h0000 with LZ_BLANK=0 → 0,0,0,0.
4. Display showing 1234; load 16'h9999 during the digit1 slot → digits 2 and 3 of the current frame still show 2,1; all four show 9 from the next digit0 slot.
5. load 16'h1111, then 16'h2222 before the boundary → the frame shows 2222. A load of 16'h3333 in the exact cycle of the 3→0 wrap → that digit0 slot shows 3; pending=0 afterwards.
6. rst_n=0 for 1 cycle in the middle of a digit2 slot with pending=1 → next cycle anode=1111, index 0, active=0; the pending value is never displayed.
